// File: rtl/data_ram_responder_pkg.sv
// Shared types and constants for the data-RAM responder and its byte-enable RAM.
package data_ram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int   BE_WIDTH = 4;
    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;

endpackage

// File: rtl/ram_array_be.sv
// Synchronous single-port word RAM with byte-lane write enables and a registered read port.
module ram_array_be
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Lane-masked write; storage is never reset.
    always_ff @(posedge clk_i) begin
        if (en_i == ENABLE && we_i == ENABLE) begin
            for (int n = 0; n < BE_WIDTH; n++) begin
                if (be_i[n]) begin
                    mem_r[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Read port returns zero on any cycle without an enabled read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= '0;
        end else if (en_i == ENABLE && we_i == DISABLE) begin
            rdata_r <= mem_r[addr_i];
        end else begin
            rdata_r <= '0;
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/data_ram_responder.sv
// Single-outstanding bus responder: accepts a read/write, waits WAIT_STATES cycles,
// commits to the byte-enable RAM and issues a one-cycle response.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_ce_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BE_WIDTH-1:0]   req_be_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN_C = 64'(DEPTH_WORDS) * 64'd4;
    localparam logic [3:0]  WS_C   = 4'(WAIT_STATES);

    state_t                state_r, state_nxt_s;
    logic [3:0]            cnt_r;
    logic                  cap_we_r, cap_inr_r;
    logic [IDX_W-1:0]      cap_idx_r;
    logic [DATA_WIDTH-1:0] cap_wdata_r;
    logic [BE_WIDTH-1:0]   cap_be_r;
    logic                  rsp_valid_r, rsp_err_r;

    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  in_range_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic                  accept_s, commit_s;
    logic                  c_we_s, c_inr_s;
    logic [IDX_W-1:0]      c_idx_s;
    logic [DATA_WIDTH-1:0] c_wdata_s;
    logic [BE_WIDTH-1:0]   c_be_s;
    logic                  ram_en_s;

    assign offset_s    = req_addr_i - BASE_ADDR;
    assign in_range_s  = (req_addr_i >= BASE_ADDR) && (64'(offset_s) < SPAN_C);
    assign req_idx_s   = offset_s[IDX_W+1:2];
    assign req_ready_o = (state_r == ST_IDLE);

    // Next-state logic; the commit edge is the one entering RESP.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_ce_i == ENABLE) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_RESP;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_RESP;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // With no wait states the commit coincides with acceptance, so use the live request.
    always_comb begin
        c_we_s    = cap_we_r;
        c_inr_s   = cap_inr_r;
        c_idx_s   = cap_idx_r;
        c_wdata_s = cap_wdata_r;
        c_be_s    = cap_be_r;
        if (WAIT_STATES == 0) begin
            c_we_s    = req_we_i;
            c_inr_s   = in_range_s;
            c_idx_s   = req_idx_s;
            c_wdata_s = req_wdata_i;
            c_be_s    = req_be_i;
        end else begin
            c_we_s    = cap_we_r;
        end
    end

    assign ram_en_s = commit_s && c_inr_s;

    // State register and wait-state counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r <= WS_C;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Request capture at acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_we_r    <= DISABLE;
            cap_inr_r   <= 1'b0;
            cap_idx_r   <= '0;
            cap_wdata_r <= '0;
            cap_be_r    <= '0;
        end else if (accept_s) begin
            cap_we_r    <= req_we_i;
            cap_inr_r   <= in_range_s;
            cap_idx_r   <= req_idx_s;
            cap_wdata_r <= req_wdata_i;
            cap_be_r    <= req_be_i;
        end
    end

    // Response strobe and error flag live exactly for the RESP cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= commit_s;
            rsp_err_r   <= commit_s && !c_inr_s;
        end
    end

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_err_o   = rsp_err_r;

    ram_array_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (ram_en_s),
        .we_i    (c_we_s),
        .addr_i  (c_idx_s),
        .be_i    (c_be_s),
        .wdata_i (c_wdata_s),
        .rdata_o (rsp_rdata_o)
    );

endmodule
